// File: rtl/logic4_pipe_if.sv
// Operand/result handshake bundle for logic4_pipe; ZERO/ONES flags exist only with LOGIC4_FLAGS_EN.
// slave = the pipe itself, master = producer and consumer side.
interface logic4_pipe_if #(parameter int N = 8);
   logic [N-1:0] in0;
   logic [N-1:0] in1;
   logic [N-1:0] in2;
   logic [N-1:0] in3;
   logic [3:0]   mask;
   logic [2:0]   op;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] y;
   logic         out_valid;
   logic         out_ready;
`ifdef LOGIC4_FLAGS_EN
   logic         zero;
   logic         ones;
`endif

   modport slave (
      input  in0, in1, in2, in3, mask, op, in_valid, out_ready,
      output in_ready, y, out_valid
`ifdef LOGIC4_FLAGS_EN
      , output zero, ones
`endif
   );

   modport master (
      output in0, in1, in2, in3, mask, op, in_valid, out_ready,
      input  in_ready, y, out_valid
`ifdef LOGIC4_FLAGS_EN
      , input zero, ones
`endif
   );
endinterface

// File: rtl/logic4_pipe.sv
// Pipelined masked 4-operand bitwise logic unit (NAND/AND/NOR/OR/XNOR/XOR/PASS/INV); LOGIC4_FLAGS_EN adds ZERO/ONES.
// Latency STAGES (1 or 2) cycles, one result per cycle.
// Backpressure: elastic valid stages, in_ready is combinational from out_ready (no skid buffer).
module logic4_pipe #(
   parameter int N      = 8,
   parameter int STAGES = 2
) (
   input logic clk,
   input logic rst_n,
   logic4_pipe_if.slave bus
);

   function automatic logic [N-1:0] calc(input logic [2:0] op,
                                         input logic [N-1:0] a, b, c, d);
      case (op)
         3'd0:    calc = ~(a & b & c & d);
         3'd1:    calc = a & b & c & d;
         3'd2:    calc = ~(a | b | c | d);
         3'd3:    calc = a | b | c | d;
         3'd4:    calc = ~(a ^ b ^ c ^ d);
         3'd5:    calc = a ^ b ^ c ^ d;
         3'd6:    calc = a;
         default: calc = ~a;
      endcase
   endfunction

   // Masked operands take the identity of the op so they drop out of the reduction.
   logic [N-1:0] ident, m0, m1, m2, m3;
   always_comb begin
      ident = (bus.op == 3'd0 || bus.op == 3'd1) ? {N{1'b1}} : {N{1'b0}};
      m0    = (bus.mask[0] || bus.op[2:1] == 2'b11) ? bus.in0 : ident;
      m1    = bus.mask[1] ? bus.in1 : ident;
      m2    = bus.mask[2] ? bus.in2 : ident;
      m3    = bus.mask[3] ? bus.in3 : ident;
   end

   logic         v2;
   logic [N-1:0] y_q;
   logic         s2_load;
   logic         in_rdy;
   logic         c_vld;
   logic [2:0]   c_op;
   logic [N-1:0] ca, cb, cc, cd;
   logic [N-1:0] result;

   assign s2_load = !v2 || bus.out_ready;

   generate
      if (STAGES == 2) begin : g_two
         logic         v1;
         logic [2:0]   op1;
         logic [N-1:0] a1, b1, c1, d1;
         logic         s1_load;

         assign s1_load = !v1 || s2_load;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v1  <= 1'b0;
               op1 <= 3'd0;
               a1  <= '0;
               b1  <= '0;
               c1  <= '0;
               d1  <= '0;
            end else if (s1_load) begin
               v1 <= bus.in_valid;
               if (bus.in_valid) begin
                  op1 <= bus.op;
                  a1  <= m0;
                  b1  <= m1;
                  c1  <= m2;
                  d1  <= m3;
               end
            end
         end

         assign in_rdy = s1_load;
         assign c_vld  = v1;
         assign c_op   = op1;
         assign ca     = a1;
         assign cb     = b1;
         assign cc     = c1;
         assign cd     = d1;
      end else begin : g_one
         assign in_rdy = s2_load;
         assign c_vld  = bus.in_valid;
         assign c_op   = bus.op;
         assign ca     = m0;
         assign cb     = m1;
         assign cc     = m2;
         assign cd     = m3;
      end
   endgenerate

   assign result = calc(c_op, ca, cb, cc, cd);

`ifdef LOGIC4_FLAGS_EN
   logic zero_q, ones_q;
`endif

   // Y only loads on a valid item, so it holds through stalls and empty cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2  <= 1'b0;
         y_q <= '0;
`ifdef LOGIC4_FLAGS_EN
         zero_q <= 1'b0;
         ones_q <= 1'b0;
`endif
      end else if (s2_load) begin
         v2 <= c_vld;
         if (c_vld) begin
            y_q <= result;
`ifdef LOGIC4_FLAGS_EN
            zero_q <= (result == {N{1'b0}});
            ones_q <= (result == {N{1'b1}});
`endif
         end
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.y         = y_q;
   assign bus.out_valid = v2;
`ifdef LOGIC4_FLAGS_EN
   assign bus.zero = zero_q;
   assign bus.ones = ones_q;
`endif

endmodule

// File: tb/tb_logic4_pipe.sv
// Drives a STAGES=2 and a STAGES=1 logic4_pipe with identical stimulus and checks each
// against its own occupancy/latency model built from per-bit operand counts.
module tb_logic4_pipe;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic4_pipe_if #(.N(8)) bus2 ();
   logic4_pipe_if #(.N(8)) bus1 ();

   logic4_pipe #(.N(8), .STAGES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   logic4_pipe #(.N(8), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   typedef struct {
      logic [7:0] y;
      int         vis;
   } item_t;

   item_t      fifo [2][8];
   int         head [2];
   int         tail [2];
   logic [7:0] last_y [2];
   bit         loaded [2];
   int         edge_n = 0;
   int         checks = 0;
   int         passes = 0;
   int         fails  = 0;

   logic       iv, ordy, k_use;
   logic [2:0] op;
   logic [3:0] mask;
   logic [7:0] x0, x1, x2, x3, k_val;

   function automatic int stg(int d);
      return (d == 0) ? 2 : 1;
   endfunction

   // Per bit: count the included operands that are 1 and apply the op's rule.
   function automatic logic [7:0] ref_y(logic [2:0] o, logic [3:0] m,
                                        logic [7:0] v0, logic [7:0] v1,
                                        logic [7:0] v2, logic [7:0] v3);
      logic [7:0] v [4];
      logic [7:0] r;
      int n, ones;
      v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         n = 0;
         ones = 0;
         for (int k = 0; k < 4; k++)
            if (m[k]) begin
               n++;
               ones += int'(v[k][i]);
            end
         case (o)
            3'd0:    r[i] = !(ones == n);
            3'd1:    r[i] = (ones == n);
            3'd2:    r[i] = !(ones > 0);
            3'd3:    r[i] = (ones > 0);
            3'd4:    r[i] = (ones % 2 == 0);
            3'd5:    r[i] = (ones % 2 == 1);
            3'd6:    r[i] = v0[i];
            default: r[i] = !v0[i];
         endcase
      end
      return r;
   endfunction

   function automatic logic dut_rdy(int d);
      return (d == 0) ? bus2.in_ready : bus1.in_ready;
   endfunction
   function automatic logic dut_vld(int d);
      return (d == 0) ? bus2.out_valid : bus1.out_valid;
   endfunction
   function automatic logic [7:0] dut_y(int d);
      return (d == 0) ? bus2.y : bus1.y;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic apply();
      bus2.in_valid = iv;  bus1.in_valid = iv;
      bus2.out_ready = ordy; bus1.out_ready = ordy;
      bus2.op = op;   bus1.op = op;
      bus2.mask = mask; bus1.mask = mask;
      bus2.in0 = x0; bus1.in0 = x0;
      bus2.in1 = x1; bus1.in1 = x1;
      bus2.in2 = x2; bus1.in2 = x2;
      bus2.in3 = x3; bus1.in3 = x3;
   endtask

   task automatic tick();
      bit acc [2];
      bit pop [2];
      bit rdy, vexp;
      int cnt;
      logic [7:0] val;
      apply();
      #1;
      val = k_use ? k_val : ref_y(op, mask, x0, x1, x2, x3);
      for (int d = 0; d < 2; d++) begin
         cnt = tail[d] - head[d];
         rdy = (cnt < stg(d)) || ordy;
         check($sformatf("s%0d in_ready", stg(d)), {31'd0, dut_rdy(d)}, {31'd0, rdy});
         acc[d] = iv && rdy;
         pop[d] = (cnt > 0) && (fifo[d][head[d] % 8].vis <= edge_n) && ordy;
      end
      @(posedge clk);
      edge_n++;
      #1;
      for (int d = 0; d < 2; d++) begin
         if (pop[d]) head[d]++;
         if (acc[d]) begin
            fifo[d][tail[d] % 8].y   = val;
            fifo[d][tail[d] % 8].vis = edge_n + stg(d) - 1;
            tail[d]++;
         end
         vexp = (tail[d] > head[d]) && (fifo[d][head[d] % 8].vis <= edge_n);
         if (vexp) begin
            last_y[d] = fifo[d][head[d] % 8].y;
            loaded[d] = 1'b1;
         end
         check($sformatf("s%0d out_valid", stg(d)), {31'd0, dut_vld(d)}, {31'd0, vexp});
         check($sformatf("s%0d y", stg(d)), {24'd0, dut_y(d)}, {24'd0, last_y[d]});
`ifdef LOGIC4_FLAGS_EN
         check($sformatf("s%0d zero", stg(d)), {31'd0, (d == 0) ? bus2.zero : bus1.zero},
               {31'd0, loaded[d] && last_y[d] == 8'h00});
         check($sformatf("s%0d ones", stg(d)), {31'd0, (d == 0) ? bus2.ones : bus1.ones},
               {31'd0, loaded[d] && last_y[d] == 8'hFF});
`endif
      end
   endtask

   task automatic send(input logic [2:0] o, input logic [3:0] m, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c, input logic [7:0] e,
                       input logic [7:0] k);
      iv = 1'b1; ordy = 1'b1; k_use = 1'b1; k_val = k;
      op = o; mask = m; x0 = a; x1 = b; x2 = c; x3 = e;
      tick();
   endtask

   task automatic idle(input int n);
      iv = 1'b0; ordy = 1'b1; k_use = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rand_ops();
      op = 3'($urandom_range(0, 7));
      mask = 4'($urandom_range(0, 15));
      x0 = 8'($urandom_range(0, 255));
      x1 = 8'($urandom_range(0, 255));
      x2 = 8'($urandom_range(0, 255));
      x3 = 8'($urandom_range(0, 255));
   endtask

   task automatic pulse_reset();
      iv = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("s%0d rst out_valid", stg(d)), {31'd0, dut_vld(d)}, 32'd0);
         check($sformatf("s%0d rst y", stg(d)), {24'd0, dut_y(d)}, 32'd0);
         head[d] = tail[d];
         last_y[d] = 8'h00;
         loaded[d] = 1'b0;
      end
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         head[d] = 0; tail[d] = 0; last_y[d] = 8'h00; loaded[d] = 1'b0;
      end
      rst_n = 1'b0;
      iv = 1'b0; ordy = 1'b1; k_use = 1'b0; k_val = 8'h00;
      op = 3'd0; mask = 4'h0; x0 = 8'h00; x1 = 8'h00; x2 = 8'h00; x3 = 8'h00;
      apply();
      #12;
      rst_n = 1'b1;

      idle(2);

      send(3'd0, 4'hF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
      send(3'd0, 4'hF, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h01);
      idle(3);

      send(3'd1, 4'b0011, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'h30);
      send(3'd3, 4'b0011, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'hFC);
      send(3'd5, 4'b0011, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'hCC);
      send(3'd0, 4'b0000, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'h00);
      send(3'd2, 4'b0000, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'hFF);
      send(3'd6, 4'b0000, 8'h00, 8'h5A, 8'hA5, 8'hFF, 8'h00);
      send(3'd7, 4'b0000, 8'h00, 8'h5A, 8'hA5, 8'hFF, 8'hFF);
      idle(3);

      // Back-to-back stream of 6 random operands.
      iv = 1'b1; ordy = 1'b1; k_use = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rand_ops();
         tick();
      end
      idle(3);

      // Stall the consumer for 5 cycles while the producer keeps offering.
      iv = 1'b1; ordy = 1'b0; k_use = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rand_ops();
         tick();
      end
      idle(4);

      // Two operands in flight, then an asynchronous reset.
      iv = 1'b1; ordy = 1'b0; k_use = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rand_ops();
         tick();
      end
      pulse_reset();
      idle(4);

      // Random traffic with random producer and consumer stalls.
      k_use = 1'b0;
      for (int i = 0; i < 400; i++) begin
         rand_ops();
         iv = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         tick();
      end
      idle(4);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
